// File: rtl/larson_scanner_gen2.sv
// LED scanner: one lit head swept across LED_COUNT active-low outputs, with
// bounce / wrap-up / wrap-down / hold modes, step prescaler and a PWM-dimmed tail.

module larson_led_cell #(
  parameter int IDX = 0,
  parameter int PW  = 4,
  parameter int TL  = 1
) (
  input  logic [PW-1:0]         head_pos,
  input  logic [TL-1:0][PW-1:0] tail_pos,
  input  logic [TL-1:0]         tail_on,
  output logic                  sel_n
);
  logic lit;
  always_comb begin
    lit = (head_pos == PW'(IDX));
    for (int j = 0; j < TL; j++)
      if (tail_on[j] && tail_pos[j] == PW'(IDX)) lit = 1'b1;
  end
  assign sel_n = ~lit;
endmodule

module larson_scanner_gen2 #(
  parameter int LED_COUNT      = 16,
  parameter int PRESCALE_WIDTH = 16,
  parameter int TAIL_LEN       = 2
) (
  input  logic                          i_clk,
  input  logic                          i_n_rst,
  input  logic                          i_en,
  input  logic                          i_sync,
  input  logic [1:0]                    i_mode,
  input  logic [PRESCALE_WIDTH-1:0]     i_period,
  output logic [LED_COUNT-1:0]          o_selection,
  output logic [$clog2(LED_COUNT)-1:0]  o_position,
  output logic                          o_dir,
  output logic                          o_tick,
  output logic                          o_wrap
);
  localparam int PW = $clog2(LED_COUNT);
  localparam int TL = (TAIL_LEN == 0) ? 1 : TAIL_LEN;
  localparam logic [PW-1:0] LAST = PW'(LED_COUNT - 1);
  localparam logic [1:0] M_BOUNCE = 2'b00, M_UP = 2'b01, M_DOWN = 2'b10;

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [PW-1:0]             pos, nxt_pos;
  logic                      dir, nxt_dir;
  logic                      step, moved, wrap_ev;
  logic [2:0]                pwm;
  logic [TL-1:0][PW-1:0]     tail_pos;
  logic [TL-1:0]             tail_vld, tail_on;

  assign step = i_en && (cnt >= i_period);

  always_comb begin
    nxt_pos = pos;
    nxt_dir = dir;
    moved   = 1'b0;
    wrap_ev = 1'b0;
    if (step) begin
      unique case (i_mode)
        M_BOUNCE: begin
          moved = 1'b1;
          if (!dir) begin
            if (pos == LAST) begin nxt_pos = LAST - 1'b1; nxt_dir = 1'b1; wrap_ev = 1'b1; end
            else nxt_pos = pos + 1'b1;
          end else begin
            if (pos == '0) begin nxt_pos = PW'(1); nxt_dir = 1'b0; wrap_ev = 1'b1; end
            else nxt_pos = pos - 1'b1;
          end
        end
        M_UP: begin
          moved   = 1'b1;
          nxt_dir = 1'b0;
          if (pos == LAST) begin nxt_pos = '0; wrap_ev = 1'b1; end
          else nxt_pos = pos + 1'b1;
        end
        M_DOWN: begin
          moved   = 1'b1;
          nxt_dir = 1'b1;
          if (pos == '0) begin nxt_pos = LAST; wrap_ev = 1'b1; end
          else nxt_pos = pos - 1'b1;
        end
        default: ;  // hold: tick only
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      cnt <= '0; pos <= '0; dir <= 1'b0; pwm <= '0; o_tick <= 1'b0; o_wrap <= 1'b0;
    end else begin
      pwm <= pwm + 1'b1;
      if (i_sync) begin
        cnt <= '0; pos <= '0; dir <= 1'b0; o_tick <= 1'b0; o_wrap <= 1'b0;
      end else begin
        if (step)      cnt <= '0;
        else if (i_en) cnt <= cnt + 1'b1;
        pos    <= nxt_pos;
        dir    <= nxt_dir;
        o_tick <= step;
        o_wrap <= wrap_ev;
      end
    end
  end

  // Tail history: entry 0 is the most recent previous head position.
  generate
    if (TAIL_LEN > 0) begin : g_tail
      always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
          tail_pos <= '0; tail_vld <= '0;
        end else if (i_sync) begin
          tail_vld <= '0;
        end else if (moved) begin
          tail_pos[0] <= pos;
          tail_vld[0] <= 1'b1;
          for (int j = 1; j < TL; j++) begin
            tail_pos[j] <= tail_pos[j-1];
            tail_vld[j] <= tail_vld[j-1];
          end
        end
      end
    end else begin : g_no_tail
      assign tail_pos = '0;
      assign tail_vld = '0;
    end
  endgenerate

  genvar j, k;
  generate
    for (j = 0; j < TL; j++) begin : g_duty
      assign tail_on[j] = tail_vld[j] && (pwm < 3'(8 >> (j + 1)));
    end
    for (k = 0; k < LED_COUNT; k++) begin : g_led
      larson_led_cell #(.IDX(k), .PW(PW), .TL(TL)) u_cell (
        .head_pos (pos),
        .tail_pos (tail_pos),
        .tail_on  (tail_on),
        .sel_n    (o_selection[k])
      );
    end
  endgenerate

  assign o_position = pos;
  assign o_dir      = dir;
endmodule

// File: tb/tb_larson_scanner_gen2.sv
// Directed + random bench for larson_scanner_gen2 against a queue-based scanner model.
module tb_larson_scanner_gen2;
  localparam int N = 16, PWD = 16, TAIL = 2;

  logic            clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic [PWD-1:0]  period = '0;
  logic [N-1:0]    sel;
  logic [3:0]      position;
  logic            dir, tick, wrap;

  int n_chk = 0, n_fail = 0;
  int m_pos, m_dir, m_cnt, m_pwm, m_tick, m_wrap;
  int hist[$];
  int c5, c4, c3, nt;

  larson_scanner_gen2 #(.LED_COUNT(N), .PRESCALE_WIDTH(PWD), .TAIL_LEN(TAIL)) dut (
    .i_clk(clk), .i_n_rst(rst_n), .i_en(en), .i_sync(sync), .i_mode(mode),
    .i_period(period), .o_selection(sel), .o_position(position), .o_dir(dir),
    .o_tick(tick), .o_wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_cnt = 0; m_pwm = 0; m_tick = 0; m_wrap = 0;
    hist.delete();
  endtask

  // One clock of the scanner rules, using the inputs held across the edge.
  task automatic model_edge();
    int old;
    if (!rst_n) begin model_reset(); return; end
    m_pwm = (m_pwm + 1) % 8;
    if (sync) begin
      m_pos = 0; m_dir = 0; m_cnt = 0; m_tick = 0; m_wrap = 0; hist.delete();
      return;
    end
    m_wrap = 0;
    m_tick = (en && m_cnt >= int'(period)) ? 1 : 0;
    if (!m_tick) begin
      if (en) m_cnt++;
      return;
    end
    m_cnt = 0;
    if (mode == 2'b11) return;
    old = m_pos;
    case (mode)
      2'b00: begin
        if (m_dir == 0 && m_pos == N-1) begin m_pos = N-2; m_dir = 1; m_wrap = 1; end
        else if (m_dir == 1 && m_pos == 0) begin m_pos = 1; m_dir = 0; m_wrap = 1; end
        else m_pos += (m_dir == 0) ? 1 : -1;
      end
      2'b01: begin m_dir = 0; m_wrap = (m_pos == N-1); m_pos = (m_pos + 1) % N; end
      default: begin m_dir = 1; m_wrap = (m_pos == 0); m_pos = (m_pos + N - 1) % N; end
    endcase
    hist.push_front(old);
    if (hist.size() > TAIL) void'(hist.pop_back());
  endtask

  function automatic logic [N-1:0] exp_sel();
    logic [N-1:0] e = '1;
    e[m_pos] = 1'b0;
    for (int j = 0; j < hist.size(); j++)
      if (hist[j] != m_pos && m_pwm < (8 >> (j + 1))) e[hist[j]] = 1'b0;
    return e;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".sel"},  32'(sel),      32'(exp_sel()));
    chk({tag, ".pos"},  32'(position), m_pos);
    chk({tag, ".dir"},  32'(dir),      m_dir);
    chk({tag, ".tick"}, 32'(tick),     m_tick);
    chk({tag, ".wrap"}, 32'(wrap),     m_wrap);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst.sel",  32'(sel),      32'h0000_FFFE);
    chk("rst.pos",  32'(position), 0);
    chk("rst.tick", 32'(tick),     0);
    for (int i = 0; i < 3; i++) cycle("rst_hold");
    rst_n = 1'b1;

    // Ascend to 5 with period 0, then freeze and measure the tail duty
    en = 1'b1; mode = 2'b00; period = 0;
    for (int i = 0; i < 20 && m_pos != 5; i++) cycle("to5");
    chk("reach5", 32'(position), 5);
    en = 1'b0; c5 = 0; c4 = 0; c3 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle("pwm");
      c5 += int'(!sel[5]); c4 += int'(!sel[4]); c3 += int'(!sel[3]);
    end
    chk("duty.led5", c5, 16);
    chk("duty.led4", c4, 8);
    chk("duty.led3", c3, 4);

    en = 1'b1;
    for (int i = 0; i < 40; i++) cycle("bounce");
    mode = 2'b01; period = 3;
    for (int i = 0; i < 70; i++) cycle("wrap_up");
    mode = 2'b10;
    for (int i = 0; i < 70; i++) cycle("wrap_down");

    // Sync at 9, then freeze
    mode = 2'b01; period = 0;
    for (int i = 0; i < 20 && m_pos != 9; i++) cycle("to9");
    chk("reach9", 32'(position), 9);
    sync = 1'b1; cycle("sync");
    sync = 1'b0;
    chk("sync.sel", 32'(sel), 32'h0000_FFFE);
    en = 1'b0; nt = 0;
    for (int i = 0; i < 20; i++) begin cycle("freeze"); nt += int'(tick); end
    chk("freeze.ticks", nt, 0);

    // Hold, then resume bounce while descending
    en = 1'b1; mode = 2'b11; period = 1;
    for (int i = 0; i < 10; i++) cycle("hold");
    mode = 2'b00; period = 0;
    for (int i = 0; i < 40 && !(m_dir == 1 && m_pos == 10); i++) cycle("to_desc");
    chk("desc10", 32'({dir, position}), 32'h1A);
    mode = 2'b11;
    for (int i = 0; i < 4; i++) cycle("hold2");
    mode = 2'b00;
    for (int i = 0; i < 6; i++) cycle("resume");

    for (int i = 0; i < 500; i++) begin
      en     = ($urandom % 4) != 0;
      sync   = ($urandom % 32) == 0;
      mode   = 2'($urandom);
      if ($urandom % 8 == 0) period = PWD'($urandom % 5);
      cycle("rand");
    end
    sync = 1'b0;

    // Async reset in the middle of a clock period
    en = 1'b1; mode = 2'b01; period = 0;
    for (int i = 0; i < 7; i++) cycle("pre_rst");
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async.sel", 32'(sel), 32'h0000_FFFE);
    chk("async.pos", 32'(position), 0);
    @(negedge clk);
    rst_n = 1'b1; period = 2;
    for (int i = 0; i < 12; i++) cycle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
